// File: rtl/speed_run_pkg.sv
// Shared types and sizing helpers for the run/pause and speed controller.
package speed_run_pkg;

    // Run-state codes are fixed because they are exported on the state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } run_state_e;

    localparam int LVL_W_DEFAULT = 32'd3;
    localparam int MAX_LVL       = (32'd1 << LVL_W_DEFAULT) - 32'd1;

    // Highest speed level for a given level width.
    function automatic int max_lvl_of(input int lvl_w);
        return (32'd1 << lvl_w) - 32'd1;
    endfunction

    // Prescaler width able to hold every count of the slowest tick period.
    function automatic int presc_width(input longint base_div, input int lvl_w);
        longint worst;
        worst = base_div << max_lvl_of(lvl_w);
        if (worst > 64'sd1) begin
            return $clog2(worst);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge press pulse
// for one raw push-button.
module btn_debounce
    import speed_run_pkg::*;
#(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int            CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          deb_r;
    logic          deb_d_r;
    logic [CW-1:0] cnt_r;

    // Synchronise the raw level and accept a change only after DEB_CYC stable cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            deb_d_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            deb_d_r <= deb_r;
            if (sync2_r == deb_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                deb_r <= ~deb_r;
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Only the debounced rising edge is an event; release produces nothing.
    assign press = deb_r & ~deb_d_r;

endmodule

// File: rtl/speed_run_ctrl.sv
// Run/pause state machine, saturating speed level and tick prescaler driven by
// three debounced push-buttons. The datapath advances only on tick.
module speed_run_ctrl
    import speed_run_pkg::*;
#(
    parameter int DEB_CYC   = 500000,
    parameter int BASE_DIV  = 781250,
    parameter int LVL_W     = 3,
    parameter int RESET_LVL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pause_btn,
    input  logic             faster_btn,
    input  logic             slower_btn,
    output logic             tick,
    output logic             run,
    output logic [1:0]       state,
    output logic [LVL_W-1:0] speed_lvl
);

    localparam int               PW        = presc_width(BASE_DIV, LVL_W);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(max_lvl_of(LVL_W));
    localparam logic [LVL_W-1:0] LVL_RST   = LVL_W'(RESET_LVL);
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [PW:0]      BASE_W    = (PW+1)'(BASE_DIV);
    localparam logic [PW:0]      ONE_W     = (PW+1)'(1);
    localparam logic [PW-1:0]    PRESC_ONE = PW'(1);

    logic             pause_press_s;
    logic             faster_press_s;
    logic             slower_press_s;
    logic             pause_s;
    logic             faster_s;
    logic             slower_s;
    logic             clear_s;
    logic             lvl_up_s;
    logic             lvl_dn_s;
    logic [PW:0]      period_m1_s;

    run_state_e       state_r;
    run_state_e       state_nxt_s;
    logic [LVL_W-1:0] lvl_r;
    logic [LVL_W-1:0] lvl_nxt_s;
    logic [PW-1:0]    presc_r;
    logic [PW-1:0]    presc_nxt_s;
    logic             tick_r;
    logic             tick_nxt_s;
    logic             run_r;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (pause_btn),
        .press (pause_press_s)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_faster (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (faster_btn),
        .press (faster_press_s)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_slower (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (slower_btn),
        .press (slower_press_s)
    );

    // Presses are dropped while the block is disabled.
    assign pause_s  = pause_press_s & ena;
    assign faster_s = faster_press_s & ena;
    assign slower_s = slower_press_s & ena;

    // Both speed buttons together clear the controller unless it is running.
    assign clear_s  = faster_s & slower_s & (state_r != RUN);
    assign lvl_up_s = faster_s & ~slower_s & (lvl_r != LVL_MAX);
    assign lvl_dn_s = slower_s & ~faster_s & (lvl_r != LVL_ZERO);

    // Terminal prescaler count; each level below the top doubles the period.
    assign period_m1_s = (BASE_W << (LVL_MAX - lvl_r)) - ONE_W;

    // Next-state, level, prescaler and tick decisions.
    always_comb begin
        state_nxt_s = state_r;
        lvl_nxt_s   = lvl_r;
        presc_nxt_s = presc_r;
        tick_nxt_s  = 1'b0;
        if (ena) begin
            if (clear_s) begin
                state_nxt_s = IDLE;
                lvl_nxt_s   = LVL_RST;
                presc_nxt_s = {PW{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (pause_s) begin
                            state_nxt_s = RUN;
                            presc_nxt_s = {PW{1'b0}};
                        end else begin
                            state_nxt_s = IDLE;
                        end
                    end
                    RUN: begin
                        if (pause_s) begin
                            state_nxt_s = PAUSE;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end
                    PAUSE: begin
                        if (pause_s) begin
                            state_nxt_s = RUN;
                        end else begin
                            state_nxt_s = PAUSE;
                        end
                    end
                    default: begin
                        state_nxt_s = IDLE;
                    end
                endcase

                if (lvl_up_s) begin
                    lvl_nxt_s   = lvl_r + LVL_ONE;
                    presc_nxt_s = {PW{1'b0}};
                end else if (lvl_dn_s) begin
                    lvl_nxt_s   = lvl_r - LVL_ONE;
                    presc_nxt_s = {PW{1'b0}};
                end else if ((state_r == RUN) && !pause_s) begin
                    if ({1'b0, presc_r} == period_m1_s) begin
                        presc_nxt_s = {PW{1'b0}};
                        tick_nxt_s  = 1'b1;
                    end else begin
                        presc_nxt_s = presc_r + PRESC_ONE;
                    end
                end else begin
                    tick_nxt_s = 1'b0;
                end
            end
        end else begin
            state_nxt_s = state_r;
            lvl_nxt_s   = lvl_r;
            presc_nxt_s = presc_r;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            lvl_r   <= LVL_RST;
            presc_r <= {PW{1'b0}};
            tick_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            lvl_r   <= lvl_nxt_s;
            presc_r <= presc_nxt_s;
            tick_r  <= tick_nxt_s;
            run_r   <= (state_nxt_s == RUN);
        end
    end

    assign tick      = tick_r;
    assign run       = run_r;
    assign state     = state_r;
    assign speed_lvl = lvl_r;

endmodule

// File: tb/tb_speed_run_ctrl.sv
// Self-checking bench for speed_run_ctrl: vector table, timing sequences and
// randomized stimulus compared each cycle against a behavioural model.
module tb_speed_run_ctrl;

    localparam int DEB  = 4;
    localparam int BASE = 2;
    localparam int LW   = 3;
    localparam int RLVL = 3;
    localparam int TOP  = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        pause_btn;
    logic        faster_btn;
    logic        slower_btn;
    logic        tick;
    logic        run;
    logic [1:0]  state;
    logic [2:0]  speed_lvl;

    int nchk = 0;
    int nerr = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    int m_state, m_lvl, m_pre, m_tick;
    int m_s1[3], m_s2[3], m_deb[3], m_debd[3], m_cnt[3];

    typedef struct {
        logic r, e, p, f, s;
        int   n;
        int   st;
        int   lvl;
        int   rn;
    } vec_t;

    vec_t tbl[26];

    always #5 clk = ~clk;

    speed_run_ctrl #(
        .DEB_CYC   (DEB),
        .BASE_DIV  (BASE),
        .LVL_W     (LW),
        .RESET_LVL (RLVL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pause_btn  (pause_btn),
        .faster_btn (faster_btn),
        .slower_btn (slower_btn),
        .tick       (tick),
        .run        (run),
        .state      (state),
        .speed_lvl  (speed_lvl)
    );

    function automatic vec_t v(input logic r, e, p, f, s, input int n, st, lvl, rn);
        vec_t x;
        x.r = r; x.e = e; x.p = p; x.f = f; x.s = s;
        x.n = n; x.st = st; x.lvl = lvl; x.rn = rn;
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge from the inputs present at that edge.
    task automatic model_step();
        int raw[3];
        int pr[3];
        int per;
        int old_state;
        bit changed;
        raw[0] = int'(pause_btn);
        raw[1] = int'(faster_btn);
        raw[2] = int'(slower_btn);
        if (!rst_n) begin
            m_state = 0; m_lvl = RLVL; m_pre = 0; m_tick = 0;
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_debd[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) pr[i] = (m_deb[i] == 1 && m_debd[i] == 0) ? 1 : 0;
            m_tick = 0;
            if (ena) begin
                if (pr[1] == 1 && pr[2] == 1 && m_state != 1) begin
                    m_state = 0; m_lvl = RLVL; m_pre = 0;
                end else begin
                    old_state = m_state;
                    changed = 1'b0;
                    if (pr[0] == 1) begin
                        if (m_state == 1) m_state = 2;
                        else begin
                            if (m_state == 0) m_pre = 0;
                            m_state = 1;
                        end
                    end
                    if (pr[1] == 1 && pr[2] == 0 && m_lvl < TOP) begin
                        m_lvl++; changed = 1'b1;
                    end else if (pr[2] == 1 && pr[1] == 0 && m_lvl > 0) begin
                        m_lvl--; changed = 1'b1;
                    end
                    if (changed) m_pre = 0;
                    else if (old_state == 1 && m_state == 1) begin
                        per = BASE * (1 << (TOP - m_lvl));
                        m_pre++;
                        if (m_pre == per) begin
                            m_pre = 0;
                            m_tick = 1;
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                m_debd[i] = m_deb[i];
                if (m_s2[i] != m_deb[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        m_deb[i] = 1 - m_deb[i];
                        m_cnt[i] = 0;
                    end
                end else begin
                    m_cnt[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
    endtask

    // One clock: model update at the edge, DUT sampled 1 time unit later.
    task automatic step();
        int exp_v;
        int act_v;
        @(posedge clk);
        model_step();
        #1;
        if (cmp_en) begin
            exp_v = m_state * 64 + m_lvl * 4 + ((m_state == 1) ? 2 : 0) + m_tick;
            act_v = int'(state) * 64 + int'(speed_lvl) * 4 + int'(run) * 2 + int'(tick);
            check("model{state,lvl,run,tick}", act_v, exp_v);
        end
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < budget);
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic wait_run(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (run !== 1'b1 && n < budget);
        if (run !== 1'b1) n = -1;
    endtask

    task automatic wait_lvl(input int lvl, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (int'(speed_lvl) != lvl && n < budget);
        if (int'(speed_lvl) != lvl) n = -1;
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (tick === 1'b1) cnt++;
        end
    endtask

    // which: 0 pause, 1 faster, 2 slower; held 8 cycles then released 8
    task automatic press(input int which);
        if (which == 0) pause_btn = 1'b1;
        else if (which == 1) faster_btn = 1'b1;
        else slower_btn = 1'b1;
        repeat (8) step();
        pause_btn = 1'b0; faster_btn = 1'b0; slower_btn = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; ena = 1'b1;
        pause_btn = 1'b0; faster_btn = 1'b0; slower_btn = 1'b0;
        step();
        cmp_en = 1'b1;

        //           r    e    p    f    s    n  st lvl run
        tbl[0]  = v(1'b0,1'b1,1'b0,1'b0,1'b0, 5, 0, 3, 0);
        tbl[1]  = v(1'b1,1'b1,1'b1,1'b0,1'b0, 3, 0, 3, 0);  // 3-cycle glitch
        tbl[2]  = v(1'b1,1'b1,1'b0,1'b0,1'b0,10, 0, 3, 0);
        tbl[3]  = v(1'b1,1'b1,1'b1,1'b0,1'b0,10, 1, 3, 1);
        tbl[4]  = v(1'b1,1'b1,1'b0,1'b0,1'b0,10, 1, 3, 1);  // release: no event
        tbl[5]  = v(1'b1,1'b1,1'b0,1'b1,1'b0, 8, 1, 4, 1);
        tbl[6]  = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 1, 4, 1);
        tbl[7]  = v(1'b1,1'b1,1'b0,1'b0,1'b1, 8, 1, 3, 1);
        tbl[8]  = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 1, 3, 1);
        tbl[9]  = v(1'b1,1'b1,1'b1,1'b0,1'b0, 8, 2, 3, 0);
        tbl[10] = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 2, 3, 0);
        tbl[11] = v(1'b1,1'b1,1'b0,1'b1,1'b0, 8, 2, 4, 0);
        tbl[12] = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 2, 4, 0);
        tbl[13] = v(1'b1,1'b1,1'b0,1'b1,1'b0, 8, 2, 5, 0);
        tbl[14] = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 2, 5, 0);
        tbl[15] = v(1'b1,1'b1,1'b0,1'b1,1'b1, 8, 0, 3, 0);  // clear from PAUSE
        tbl[16] = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 0, 3, 0);
        tbl[17] = v(1'b1,1'b1,1'b1,1'b0,1'b0, 8, 1, 3, 1);
        tbl[18] = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 1, 3, 1);
        tbl[19] = v(1'b1,1'b1,1'b0,1'b1,1'b1, 8, 1, 3, 1);  // both in RUN ignored
        tbl[20] = v(1'b1,1'b1,1'b0,1'b0,1'b0, 8, 1, 3, 1);
        tbl[21] = v(1'b1,1'b0,1'b1,1'b0,1'b0, 8, 1, 3, 1);  // ena=0 ignores presses
        tbl[22] = v(1'b1,1'b0,1'b0,1'b0,1'b0, 8, 1, 3, 1);
        tbl[23] = v(1'b1,1'b0,1'b0,1'b1,1'b0, 8, 1, 3, 1);
        tbl[24] = v(1'b1,1'b0,1'b0,1'b0,1'b0, 8, 1, 3, 1);
        tbl[25] = v(1'b0,1'b1,1'b0,1'b0,1'b0, 1, 0, 3, 0);  // reset mid-run

        for (int i = 0; i < 26; i++) begin
            rst_n = tbl[i].r; ena = tbl[i].e;
            pause_btn = tbl[i].p; faster_btn = tbl[i].f; slower_btn = tbl[i].s;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
            check($sformatf("vec%0d_lvl", i), int'(speed_lvl), tbl[i].lvl);
            check($sformatf("vec%0d_run", i), int'(run), tbl[i].rn);
            if (tbl[i].st != 1) check($sformatf("vec%0d_tick", i), int'(tick), 0);
        end
        pause_btn = 1'b0; faster_btn = 1'b0; slower_btn = 1'b0; ena = 1'b1;

        // reset, start latency and base period
        rst_n = 1'b0;
        repeat (5) step();
        check("rst_state", int'(state), 0);
        check("rst_lvl", int'(speed_lvl), 3);
        check("rst_tick", int'(tick), 0);
        rst_n = 1'b1;
        pause_btn = 1'b1;
        wait_run(20, n);
        check("start_latency", n, 7);
        pause_btn = 1'b0;
        wait_tick(100, n);
        check("first_tick", n, 32);
        wait_tick(100, n);
        check("period_lvl3", n, 32);

        // speed changes and saturation
        faster_btn = 1'b1;
        wait_lvl(4, 20, n);
        check("faster_latency", n, 7);
        faster_btn = 1'b0;
        wait_tick(100, n);
        check("tick_after_lvl4", n, 16);
        wait_tick(100, n);
        check("period_lvl4", n, 16);
        repeat (4) press(1);
        check("lvl_7", int'(speed_lvl), 7);
        wait_tick(10, n);
        wait_tick(10, n);
        check("period_lvl7", n, 2);
        press(1);
        check("lvl_sat_hi", int'(speed_lvl), 7);
        wait_tick(10, n);
        wait_tick(10, n);
        check("period_sat_hi", n, 2);
        repeat (8) press(2);
        check("lvl_sat_lo", int'(speed_lvl), 0);
        wait_tick(300, n);
        wait_tick(300, n);
        check("period_lvl0", n, 256);

        // pause at prescaler 10, then resume
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        press(0);
        wait_tick(40, n);
        repeat (4) step();
        pause_btn = 1'b1;
        repeat (6) step();
        check("pre_pause_run", int'(run), 1);
        step();
        check("paused_run", int'(run), 0);
        check("paused_state", int'(state), 2);
        step();
        pause_btn = 1'b0;
        count_ticks(100, n);
        check("paused_ticks", n, 0);
        pause_btn = 1'b1;
        wait_run(20, n);
        check("resume_latency", n, 7);
        pause_btn = 1'b0;
        wait_tick(40, n);
        check("resume_tick", n, 22);

        // ena low holds everything
        wait_tick(40, n);
        repeat (5) step();
        ena = 1'b0; pause_btn = 1'b1; faster_btn = 1'b1;
        count_ticks(50, n);
        check("ena0_ticks", n, 0);
        pause_btn = 1'b0; faster_btn = 1'b0;
        repeat (10) step();
        check("ena0_state", int'(state), 1);
        check("ena0_lvl", int'(speed_lvl), 3);
        ena = 1'b1;
        wait_tick(40, n);
        check("ena1_tick", n, 27);

        // reset mid-period
        wait_tick(40, n);
        repeat (7) step();
        rst_n = 1'b0;
        step();
        check("midrst_state", int'(state), 0);
        check("midrst_lvl", int'(speed_lvl), 3);
        check("midrst_run", int'(run), 0);
        check("midrst_tick", int'(tick), 0);
        rst_n = 1'b1;

        // randomized segments against the model
        for (int s = 0; s < 250; s++) begin
            pause_btn  = ($urandom_range(0, 3) == 0);
            faster_btn = ($urandom_range(0, 3) == 0);
            slower_btn = ($urandom_range(0, 3) == 0);
            ena        = ($urandom_range(0, 9) != 0);
            rst_n      = ($urandom_range(0, 59) != 0);
            repeat ($urandom_range(1, 14)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
